// File: rtl/cart_bus_arbiter_if.sv
// cart_bus_arbiter_if: request, cart bus and read-return signals of the cart bus arbiter
interface cart_bus_arbiter_if;
   logic        cyc_start;
   logic        cyc_end;
   logic        cpu_req;
   logic [15:0] cpu_a;
   logic        cpu_wr;
   logic [7:0]  cpu_dout;
   logic        dma_req;
   logic [15:0] dma_a;
   logic        hdma_req;
   logic [15:0] hdma_a;
   logic [7:0]  bus_din;
   logic [15:0] bus_a;
   logic        bus_rd;
   logic        bus_wr;
   logic        bus_ncs;
   logic [7:0]  bus_dout;
   logic [1:0]  gnt;
   logic        cpu_stall;
   logic [7:0]  rdata;
   logic        rvalid;
   logic [1:0]  rid;
   logic        hdma_busy;
   modport slave (
      input  cyc_start, cyc_end, cpu_req, cpu_a, cpu_wr, cpu_dout, dma_req, dma_a,
             hdma_req, hdma_a, bus_din,
      output bus_a, bus_rd, bus_wr, bus_ncs, bus_dout, gnt, cpu_stall, rdata, rvalid,
             rid, hdma_busy
   );
   modport master (
      output cyc_start, cyc_end, cpu_req, cpu_a, cpu_wr, cpu_dout, dma_req, dma_a,
             hdma_req, hdma_a, bus_din,
      input  bus_a, bus_rd, bus_wr, bus_ncs, bus_dout, gnt, cpu_stall, rdata, rvalid,
             rid, hdma_busy
   );
endinterface

// File: rtl/cart_bus_arbiter.sv
// cart_bus_arbiter: grants the cart bus to CPU, OAM DMA or HDMA once per M-cycle,
// with an HDMA block lock, and returns read data to the owner of the finished cycle.
module cart_bus_arbiter #(
   parameter int HDMA_BLOCK = 16
) (
   input logic               hclk,
   input logic               gbreset,
   cart_bus_arbiter_if.slave bus
);
   localparam int CW = HDMA_BLOCK > 1 ? $clog2(HDMA_BLOCK) : 1;
   typedef enum logic [1:0] {IDLE, CPU, DMA, HDMA} state_t;
   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [15:0]   a_nxt;
   logic          reader;
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (bus.cyc_start) begin
         if (cnt != '0 && bus.hdma_req) begin
            state_nxt = HDMA;
            cnt_nxt   = cnt - CW'(1);
         end else begin
            // counter is zero or being aborted here, so plain priority decides
            state_nxt = bus.hdma_req ? HDMA : bus.dma_req ? DMA : bus.cpu_req ? CPU : IDLE;
            cnt_nxt   = bus.hdma_req ? CW'(HDMA_BLOCK - 1) : '0;
         end
      end
   end
   assign a_nxt  = state_nxt == CPU ? bus.cpu_a : state_nxt == DMA ? bus.dma_a : bus.hdma_a;
   assign reader = state == DMA || state == HDMA || (state == CPU && !bus.bus_wr);
   assign bus.gnt       = state;
   assign bus.hdma_busy = cnt != '0 || state == HDMA;
   always_ff @(posedge hclk or posedge gbreset) begin
      if (gbreset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end
   always_ff @(posedge hclk or posedge gbreset) begin
      if (gbreset) begin
         bus.bus_a     <= '0;
         bus.bus_rd    <= 1'b0;
         bus.bus_wr    <= 1'b0;
         bus.bus_ncs   <= 1'b1;
         bus.bus_dout  <= '0;
         bus.cpu_stall <= 1'b0;
         bus.rdata     <= '0;
         bus.rvalid    <= 1'b0;
         bus.rid       <= '0;
      end else begin
         // the cycle ending here still belongs to the current owner, even on a new cyc_start
         bus.rvalid <= bus.cyc_end && reader;
         if (bus.cyc_end && reader) begin
            bus.rdata <= bus.bus_din;
            bus.rid   <= state;
         end
         if (bus.cyc_start) begin
            if (state_nxt != IDLE) bus.bus_a <= a_nxt;
            if (state_nxt == CPU) bus.bus_dout <= bus.cpu_dout;
            bus.bus_rd    <= state_nxt == DMA || state_nxt == HDMA || (state_nxt == CPU && !bus.cpu_wr);
            bus.bus_wr    <= state_nxt == CPU && bus.cpu_wr;
            bus.bus_ncs   <= !(state_nxt != IDLE && a_nxt[15:13] == 3'b101);
            bus.cpu_stall <= bus.cpu_req && state_nxt != CPU;
         end
      end
   end
endmodule
